regfile_port_master: RTL

Initiator for the register file's four-phase `re`/`rack`, `we`/`wack` strobe interface. It accepts one operand command per transaction from the pipeline: an optional write-back followed by up to two source reads. It drives the strobes, synchronises the acknowledges, and returns both operands on a valid/ready response port. It sits between decode/writeback control and the register file and is the only block that toggles `re`/`we`.

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_port_master_if.sv | 45 ++++
 rtl/ack_sync2.sv | 25 ++
 rtl/regfile_port_master.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port master.
// Holds the FSM state encoding and the phase-ordering helper.
package regfile_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_REL,
        RA_REQ,
        RA_REL,
        RB_REQ,
        RB_REL,
        RESP
    } rpm_state_t;

    // First pending phase in write, A, B order; RESP when nothing is left.
    function automatic rpm_state_t next_phase(input logic wr_pend,
                                              input logic a_pend,
                                              input logic b_pend);
        rpm_state_t nxt;
        if (wr_pend)     nxt = WR_REQ;
        else if (a_pend) nxt = RA_REQ;
        else if (b_pend) nxt = RB_REQ;
        else             nxt = RESP;
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_port_master_if.sv
// Command/response handshake and register-file strobe bundle.
// master: the port master itself; slave: pipeline plus register file side.
interface regfile_port_master_if #(
    parameter int REG_SZ = 32
);
    import regfile_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [REG_IDX_W-1:0] cmd_rs;
    logic [REG_IDX_W-1:0] cmd_rt;
    logic                 cmd_wb;
    logic [REG_IDX_W-1:0] cmd_rd;
    logic [REG_SZ-1:0]    cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [REG_SZ-1:0]    rsp_a;
    logic [REG_SZ-1:0]    rsp_b;
    logic                 rsp_err;

    logic [REG_IDX_W-1:0] r_idx;
    logic [REG_IDX_W-1:0] w_idx;
    logic                 re;
    logic                 we;
    logic [REG_SZ-1:0]    din;
    logic [REG_SZ-1:0]    dout;
    logic                 rack;
    logic                 wack;

    modport master (
        input  cmd_valid, cmd_rs, cmd_rt, cmd_wb, cmd_rd, cmd_wdata,
        input  rsp_ready, dout, rack, wack,
        output cmd_ready, rsp_valid, rsp_a, rsp_b, rsp_err,
        output r_idx, w_idx, re, we, din
    );

    modport slave (
        output cmd_valid, cmd_rs, cmd_rt, cmd_wb, cmd_rd, cmd_wdata,
        output rsp_ready, dout, rack, wack,
        input  cmd_ready, rsp_valid, rsp_a, rsp_b, rsp_err,
        input  r_idx, w_idx, re, we, din
    );

endinterface

// File: rtl/ack_sync2.sv
// Two-flop synchroniser for an asynchronous acknowledge.
// Cleared to 0 by reset; q is the second-flop output.
module ack_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/regfile_port_master.sv
// Four-phase re/rack, we/wack initiator: optional write-back, then reads A and B,
// operands returned on a valid/ready response port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; ready only once both acks read low
// WR_REQ | we high, waiting for synchronised wack = 1
// WR_REL | we low, waiting for synchronised wack = 0
// RA_REQ | re high for source A, capture dout when rack seen high
// RA_REL | re low, waiting for synchronised rack = 0
// RB_REQ | re high for source B, capture dout when rack seen high
// RB_REL | re low, waiting for synchronised rack = 0
// RESP   | response valid, held until rsp_ready
module regfile_port_master
    import regfile_pkg::*;
#(
    parameter int REG_SZ  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_port_master_if.master bus
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    if (TIMEOUT < 8) begin : g_timeout_chk
        $error("regfile_port_master: TIMEOUT must be at least 8");
    end

    rpm_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 re_q, re_d;
    logic                 we_q, we_d;
    logic [REG_IDX_W-1:0] r_idx_q, r_idx_d;
    logic [REG_IDX_W-1:0] w_idx_q, w_idx_d;
    logic [REG_SZ-1:0]    din_q, din_d;
    logic [REG_IDX_W-1:0] rs_q, rs_d;
    logic [REG_IDX_W-1:0] rt_q, rt_d;
    logic [REG_SZ-1:0]    rsp_a_q, rsp_a_d;
    logic [REG_SZ-1:0]    rsp_b_q, rsp_b_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [1:0]           warm_q, warm_d;

    logic rack_s;
    logic wack_s;
    logic cmd_ready;
    logic timed_out;
    logic in_phase;

    ack_sync2 u_rack_sync (.clk(clk), .rst_n(rst_n), .d(bus.rack), .q(rack_s));
    ack_sync2 u_wack_sync (.clk(clk), .rst_n(rst_n), .d(bus.wack), .q(wack_s));

    // The synchronisers restart at 0, so their output only means anything
    // two edges after reset; until then a responder may still hold its ack.
    assign cmd_ready = (state_q == IDLE) && !rack_s && !wack_s && warm_q[1];
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign in_phase  = (state_q != IDLE) && (state_q != RESP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        re_d      = re_q;
        we_d      = we_q;
        r_idx_d   = r_idx_q;
        w_idx_d   = w_idx_q;
        din_d     = din_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rsp_a_d   = rsp_a_q;
        rsp_b_d   = rsp_b_q;
        rsp_err_d = rsp_err_q;
        warm_d    = warm_q[1] ? warm_q : warm_q + 2'd1;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    rs_d      = bus.cmd_rs;
                    rt_d      = bus.cmd_rt;
                    w_idx_d   = bus.cmd_rd;
                    din_d     = bus.cmd_wdata;
                    rsp_a_d   = '0;
                    rsp_b_d   = '0;
                    rsp_err_d = 1'b0;
                    if (bus.cmd_rs != '0)      r_idx_d = bus.cmd_rs;
                    else if (bus.cmd_rt != '0) r_idx_d = bus.cmd_rt;
                    state_d = next_phase(bus.cmd_wb && (bus.cmd_rd != '0),
                                         bus.cmd_rs != '0, bus.cmd_rt != '0);
                end
            end
            WR_REQ: begin
                if (wack_s) begin
                    we_d    = 1'b0;
                    state_d = WR_REL;
                end
            end
            WR_REL: begin
                if (!wack_s) state_d = next_phase(1'b0, rs_q != '0, rt_q != '0);
            end
            RA_REQ: begin
                if (rack_s) begin
                    rsp_a_d = bus.dout;
                    re_d    = 1'b0;
                    state_d = RA_REL;
                end
            end
            RA_REL: begin
                if (!rack_s) begin
                    r_idx_d = (rt_q != '0) ? rt_q : r_idx_q;
                    state_d = next_phase(1'b0, 1'b0, rt_q != '0);
                end
            end
            RB_REQ: begin
                if (rack_s) begin
                    rsp_b_d = bus.dout;
                    re_d    = 1'b0;
                    state_d = RB_REL;
                end
            end
            RB_REL: begin
                if (!rack_s) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A stalled phase abandons everything still pending.
        if (in_phase && (state_d == state_q) && timed_out) begin
            re_d      = 1'b0;
            we_d      = 1'b0;
            rsp_err_d = 1'b1;
            state_d   = RESP;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == WR_REQ) we_d = 1'b1;
            if ((state_d == RA_REQ) || (state_d == RB_REQ)) re_d = 1'b1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            r_idx_q     <= '0;
            w_idx_q     <= '0;
            din_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            warm_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            re_q        <= re_d;
            we_q        <= we_d;
            r_idx_q     <= r_idx_d;
            w_idx_q     <= w_idx_d;
            din_q       <= din_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            warm_q      <= warm_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_a     = rsp_a_q;
    assign bus.rsp_b     = rsp_b_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.r_idx     = r_idx_q;
    assign bus.w_idx     = w_idx_q;
    assign bus.re        = re_q;
    assign bus.we        = we_q;
    assign bus.din       = din_q;

endmodule
